// File: rtl/execute_pkg.sv
// Shared opcode and FSM state encodings for execute_control.
package execute_pkg;

  typedef enum logic [2:0] {
    OP_MOV = 3'd0,
    OP_ADD = 3'd1,
    OP_ADC = 3'd2,
    OP_SUB = 3'd3,
    OP_ROL = 3'd4,
    OP_ROR = 3'd5
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_ROTATE,
    ST_WRITE
  } state_e;

  // Codes 6 and 7 are reserved; they complete without writing the register file.
  function automatic logic op_is_legal(input logic [2:0] code);
    return code <= OP_ROR;
  endfunction

  function automatic logic op_is_alu(input logic [2:0] code);
    return (code == OP_ADD) || (code == OP_ADC) || (code == OP_SUB);
  endfunction

  function automatic logic op_is_rot(input logic [2:0] code);
    return (code == OP_ROL) || (code == OP_ROR);
  endfunction

endpackage

// File: rtl/execute_rotate_step.sv
// Combinational single-bit rotate of a BIT_WIDTH word, left or right.
module execute_rotate_step #(
  parameter int BIT_WIDTH = 32
) (
  input  logic [BIT_WIDTH-1:0] data_i,
  input  logic                 ror_i,
  output logic [BIT_WIDTH-1:0] data_o
);

  assign data_o = ror_i ? {data_i[0], data_i[BIT_WIDTH-1:1]}
                        : {data_i[BIT_WIDTH-2:0], data_i[BIT_WIDTH-1]};

endmodule

// File: rtl/execute_control.sv
// Multi-cycle execute sequencer: read two registers, ALU op or bit-serial rotate, write back.
// Optional carry flag register enabled by defining EXECUTE_CONTROL_CARRY_EN.
module execute_control
  import execute_pkg::*;
#(
  parameter int BIT_WIDTH   = 32,
  parameter int INDEX_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [2:0]                   op_code,
  input  logic [INDEX_WIDTH-1:0]       op_index_operand_1,
  input  logic [INDEX_WIDTH-1:0]       op_index_operand_2,
  input  logic [INDEX_WIDTH-1:0]       op_index_result,
  input  logic [$clog2(BIT_WIDTH)-1:0] op_count,
  output logic [INDEX_WIDTH-1:0]       rf_read_index_1,
  output logic [INDEX_WIDTH-1:0]       rf_read_index_2,
  input  logic [BIT_WIDTH-1:0]         rf_read_data_1,
  input  logic [BIT_WIDTH-1:0]         rf_read_data_2,
  output logic                         rf_write_enable,
  output logic [INDEX_WIDTH-1:0]       rf_write_index,
  output logic [BIT_WIDTH-1:0]         rf_write_data,
  output logic                         busy,
  output logic                         done,
  output logic                         carry_flag
);

  localparam int CNT_W = $clog2(BIT_WIDTH);

  state_e                 state_q, state_d;
  logic [2:0]             op_q;
  logic [INDEX_WIDTH-1:0] idx1_q, idx2_q, idxr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [BIT_WIDTH-1:0]   op1_q, op2_q, res_q;
  logic                   alu_c_q;
  logic [BIT_WIDTH:0]     alu_w;
  logic [BIT_WIDTH-1:0]   rot_w;
  logic                   rot_dir_w;
  logic                   cin_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    op_ready        = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    rf_write_enable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        op_ready = 1'b1;
        busy     = 1'b0;
        if (op_valid) state_d = ST_READ;
      end
      ST_READ: begin
        if (op_is_alu(op_q))                        state_d = ST_EXEC;
        else if (op_is_rot(op_q) && cnt_q != '0)    state_d = ST_ROTATE;
        else                                        state_d = ST_WRITE;
      end
      ST_EXEC:   state_d = ST_WRITE;
      ST_ROTATE: if (cnt_q == CNT_W'(1)) state_d = ST_WRITE;
      ST_WRITE: begin
        done            = 1'b1;
        rf_write_enable = op_is_legal(op_q);
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Carry-out lands in bit BIT_WIDTH; for SUB the zero-extended difference makes it the borrow.
  always_comb begin
    alu_w = '0;
    if (op_q == OP_SUB) alu_w = {1'b0, op1_q} - {1'b0, op2_q};
    else                alu_w = {1'b0, op1_q} + {1'b0, op2_q} + {{BIT_WIDTH{1'b0}}, cin_w};
  end

  assign rot_dir_w = (op_q == OP_ROR);

  execute_rotate_step #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_rotate_step (
    .data_i(res_q),
    .ror_i (rot_dir_w),
    .data_o(rot_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      idx1_q  <= '0;
      idx2_q  <= '0;
      idxr_q  <= '0;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      alu_c_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (op_valid) begin
          op_q   <= op_code;
          idx1_q <= op_index_operand_1;
          idx2_q <= op_index_operand_2;
          idxr_q <= op_index_result;
          cnt_q  <= op_count;
        end
        ST_READ: begin
          op1_q <= rf_read_data_1;
          op2_q <= rf_read_data_2;
          res_q <= rf_read_data_1;
        end
        ST_EXEC: begin
          res_q   <= alu_w[BIT_WIDTH-1:0];
          alu_c_q <= alu_w[BIT_WIDTH];
        end
        ST_ROTATE: begin
          res_q <= rot_w;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rf_read_index_1 = idx1_q;
  assign rf_read_index_2 = idx2_q;
  assign rf_write_index  = idxr_q;
  assign rf_write_data   = res_q;

`ifdef EXECUTE_CONTROL_CARRY_EN
  logic cf_q;
  logic rot_nz_q;

  // A zero-count rotate leaves the flag alone, so remember whether any rotation happened.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cf_q     <= 1'b0;
      rot_nz_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && op_valid) rot_nz_q <= (op_count != '0);
      if (state_q == ST_WRITE) begin
        case (op_q)
          OP_ADD, OP_ADC, OP_SUB: cf_q <= alu_c_q;
          OP_ROL: if (rot_nz_q) cf_q <= res_q[0];
          OP_ROR: if (rot_nz_q) cf_q <= res_q[BIT_WIDTH-1];
          default: ;
        endcase
      end
    end
  end

  assign cin_w      = (op_q == OP_ADC) && cf_q;
  assign carry_flag = cf_q;
`else
  logic unused_carry;
  assign unused_carry = alu_c_q;
  assign cin_w        = 1'b0;
  assign carry_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_execute_control.sv
// Bench for execute_control: per-cycle comparison against a transaction-level model plus literal pins.
module tb_execute_control;

`ifdef EXECUTE_CONTROL_CARRY_EN
  localparam bit CF_EN = 1'b1;
`else
  localparam bit CF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_code = '0;
  logic [2:0]  op_index_operand_1 = '0, op_index_operand_2 = '0, op_index_result = '0;
  logic [4:0]  op_count = '0;
  logic [2:0]  rf_read_index_1, rf_read_index_2, rf_write_index;
  logic [31:0] rf_read_data_1, rf_read_data_2, rf_write_data;
  logic        rf_write_enable, busy, done, carry_flag;

  execute_control dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_index_operand_1(op_index_operand_1), .op_index_operand_2(op_index_operand_2),
    .op_index_result(op_index_result), .op_count(op_count),
    .rf_read_index_1(rf_read_index_1), .rf_read_index_2(rf_read_index_2),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .rf_write_enable(rf_write_enable), .rf_write_index(rf_write_index),
    .rf_write_data(rf_write_data), .busy(busy), .done(done), .carry_flag(carry_flag)
  );

  always #5 clk = ~clk;

  // Register file environment and the model's own view of architectural registers.
  logic [31:0] rf [8] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h10, 32'h20, 32'h80000001, 32'h12345678, 32'h5A5A5A5A};
  logic [31:0] mregs [8] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h10, 32'h20, 32'h80000001, 32'h12345678, 32'h5A5A5A5A};
  assign rf_read_data_1 = rf[rf_read_index_1];
  assign rf_read_data_2 = rf[rf_read_index_2];
  always @(posedge clk) if (rf_write_enable) rf[rf_write_index] <= rf_write_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nmis = 0;

  // Current expected transaction.
  bit          active = 1'b0;
  int          acc_edge = -1000;
  int          m_lat = 2;
  bit          m_we, m_upd, m_ncf;
  logic [31:0] m_res;
  logic [2:0]  m_i1, m_i2, m_ir;
  bit          exp_cf = 1'b0;
  int          done_k;
  bit          seen_we;
  logic [31:0] seen_data;

  task automatic chk1(input string nm, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Architectural result of one operation: value, cycles to write, and flag effect.
  task automatic model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] n, output logic [31:0] r, output int lat,
                       output bit we, output bit upd, output bit ncf);
    logic [32:0] s;
    int sh;
    r = a; lat = 2; we = 1'b1; upd = 1'b0; ncf = 1'b0;
    sh = int'(n);
    case (c)
      3'd1, 3'd2: begin
        s = {1'b0, a} + {1'b0, b} + 33'((c == 3'd2 && CF_EN) ? exp_cf : 1'b0);
        r = s[31:0]; lat = 3; upd = CF_EN; ncf = s[32];
      end
      3'd3: begin r = a - b; lat = 3; upd = CF_EN; ncf = (a < b); end
      3'd4: if (sh != 0) begin
        r = (a << sh) | (a >> (32 - sh)); lat = sh + 2; upd = CF_EN; ncf = r[0];
      end
      3'd5: if (sh != 0) begin
        r = (a >> sh) | (a << (32 - sh)); lat = sh + 2; upd = CF_EN; ncf = r[31];
      end
      3'd0: ;
      default: we = 1'b0;
    endcase
  endtask

  always @(negedge clk) begin
    int k;
    bit b, d;
    if (rst) begin
      chk1("rst_op_ready", op_ready, 1'b1);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_wr_en", rf_write_enable, 1'b0);
      chk32("rst_rd_idx1", 32'(rf_read_index_1), 32'd0);
      chk32("rst_rd_idx2", 32'(rf_read_index_2), 32'd0);
      chk32("rst_wr_idx", 32'(rf_write_index), 32'd0);
      chk32("rst_wr_data", rf_write_data, 32'd0);
      chk1("rst_carry", carry_flag, 1'b0);
    end else begin
      k = cyc - acc_edge;
      b = active && (k >= 1) && (k <= m_lat);
      d = active && (k == m_lat);
      chk1("op_ready", op_ready, !b);
      chk1("busy", busy, b);
      chk1("done", done, d);
      chk1("wr_en", rf_write_enable, d && m_we);
      chk1("carry_flag", carry_flag, exp_cf);
      if (b) begin
        chk32("rd_idx1", 32'(rf_read_index_1), 32'(m_i1));
        chk32("rd_idx2", 32'(rf_read_index_2), 32'(m_i2));
      end
      if (d && m_we) begin
        chk32("wr_idx", 32'(rf_write_index), 32'(m_ir));
        chk32("wr_data", rf_write_data, m_res);
      end
      if (active && done) done_k = k;
      if (active && rf_write_enable) begin seen_we = 1'b1; seen_data = rf_write_data; end
      if (d) begin
        if (m_upd) exp_cf = m_ncf;
        if (m_we) mregs[m_ir] = m_res;
        active = 1'b0;
      end
    end
  end

  task automatic launch(input logic [2:0] c, input logic [2:0] i1, input logic [2:0] i2,
                        input logic [2:0] ir, input logic [4:0] n);
    @(negedge clk);
    op_valid = 1'b1; op_code = c; op_count = n;
    op_index_operand_1 = i1; op_index_operand_2 = i2; op_index_result = ir;
    model(c, mregs[i1], mregs[i2], n, m_res, m_lat, m_we, m_upd, m_ncf);
    m_i1 = i1; m_i2 = i2; m_ir = ir;
    done_k = -1; seen_we = 1'b0; seen_data = '0;
    acc_edge = cyc;
    active = 1'b1;
  endtask

  task automatic do_op(input string nm, input logic [2:0] c, input logic [2:0] i1,
                       input logic [2:0] i2, input logic [2:0] ir, input logic [4:0] n,
                       input int hold, input logic [31:0] lit_d, input int lit_lat,
                       input bit lit_we, input bit lit_cf);
    launch(c, i1, i2, ir, n);
    // Requests presented while busy must be dropped.
    repeat (hold + 1) begin
      @(negedge clk);
      op_code = 3'd3; op_index_operand_1 = ~i1; op_index_result = ~ir;
    end
    op_valid = 1'b0;
    for (int t = 0; t < 100 && active; t++) @(negedge clk);
    if (active) begin
      nvec++; nmis++;
      $display("FAIL %s_timeout: no completion, want latency %0d", nm, lit_lat);
      active = 1'b0;
    end
    @(negedge clk);
    chk32({nm, "_latency"}, 32'(done_k), 32'(lit_lat));
    chk1({nm, "_wrote"}, seen_we, lit_we);
    if (lit_we) chk32({nm, "_result"}, seen_data, lit_d);
    chk1({nm, "_cf"}, carry_flag, lit_cf);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    do_op("add_carry",  3'd1, 3'd1, 3'd2, 3'd7, 5'd0,  0, 32'h00000000,  3, 1'b1, CF_EN);
    do_op("adc",        3'd2, 3'd3, 3'd4, 3'd0, 5'd0,  0, CF_EN ? 32'h31 : 32'h30, 3, 1'b1, 1'b0);
    do_op("rol4",       3'd4, 3'd5, 3'd0, 3'd1, 5'd4,  3, 32'h00000018,  6, 1'b1, 1'b0);
    do_op("sub_borrow", 3'd3, 3'd3, 3'd4, 3'd3, 5'd0,  0, 32'hFFFFFFF0,  3, 1'b1, CF_EN);
    do_op("ror0",       3'd5, 3'd6, 3'd0, 3'd2, 5'd0,  0, 32'h12345678,  2, 1'b1, CF_EN);
    do_op("sub_zero",   3'd3, 3'd4, 3'd4, 3'd5, 5'd0,  0, 32'h00000000,  3, 1'b1, 1'b0);
    do_op("mov",        3'd0, 3'd6, 3'd1, 3'd4, 5'd0,  0, 32'h12345678,  2, 1'b1, 1'b0);
    do_op("illegal6",   3'd6, 3'd6, 3'd6, 3'd6, 5'd0,  0, 32'h0,         2, 1'b0, 1'b0);
    do_op("illegal7",   3'd7, 3'd1, 3'd2, 3'd3, 5'd0,  1, 32'h0,         2, 1'b0, 1'b0);
    do_op("ror4",       3'd5, 3'd6, 3'd0, 3'd5, 5'd4,  0, 32'h81234567,  6, 1'b1, CF_EN);
    do_op("rol31",      3'd4, 3'd1, 3'd0, 3'd0, 5'd31, 0, 32'h0000000C, 33, 1'b1, 1'b0);

    // Abort a long rotate with an asynchronous reset pulse.
    launch(3'd4, 3'd5, 3'd0, 3'd7, 5'd10);
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1; active = 1'b0; exp_cf = 1'b0;
    #1;
    chk1("async_rst_busy", busy, 1'b0);
    chk1("async_rst_ready", op_ready, 1'b1);
    chk1("async_rst_wr_en", rf_write_enable, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk32("abort_no_write", rf[7], 32'h00000000);
    chk1("abort_ready", op_ready, 1'b1);

    do_op("add_after_rst", 3'd1, 3'd3, 3'd4, 3'd6, 5'd0, 0, 32'h12345668, 3, 1'b1, CF_EN);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
